// File: rtl/rob_multi.sv
// Reorder buffer: in-order allocation, out-of-order writeback, up to COMMIT_W
// in-order retirements per cycle, per-entry exceptions, partial and full flush.
module rob_multi #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned IDX_W    = $clog2(DEPTH),
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PREG_W   = 6,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       alloc_valid,
  input  logic [PC_W-1:0]            alloc_pc,
  input  logic                       alloc_has_dest,
  input  logic [PREG_W-1:0]          alloc_dest,
  input  logic [PREG_W-1:0]          alloc_old_dest,
  output logic                       alloc_ready,
  output logic [IDX_W-1:0]           alloc_idx,
  input  logic                       wb_valid,
  input  logic [IDX_W-1:0]           wb_idx,
  input  logic [DATA_W-1:0]          wb_value,
  input  logic                       wb_exc,
  input  logic                       commit_ready,
  output logic [COMMIT_W-1:0]        commit_valid,
  output logic [COMMIT_W-1:0]        commit_has_dest,
  output logic [COMMIT_W*PREG_W-1:0] commit_dest,
  output logic [COMMIT_W*PREG_W-1:0] commit_old_dest,
  output logic [COMMIT_W*DATA_W-1:0] commit_value,
  output logic                       exc_valid,
  output logic [IDX_W-1:0]           exc_idx,
  output logic [PC_W-1:0]            exc_pc,
  input  logic                       flush_valid,
  input  logic [IDX_W-1:0]           flush_idx,
  input  logic                       flush_all,
  output logic [IDX_W:0]             count,
  output logic                       empty
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, exc_q, exc_d;

  logic [DEPTH-1:0]  has_dest_q;
  logic [PC_W-1:0]   pc_q       [DEPTH];
  logic [PREG_W-1:0] dest_q     [DEPTH];
  logic [PREG_W-1:0] old_dest_q [DEPTH];
  logic [DATA_W-1:0] value_q    [DEPTH];

  logic [IDX_W-1:0]    lane_idx [COMMIT_W];
  logic [COMMIT_W-1:0] elig;
  logic                chain;
  logic [CNT_W-1:0]    n_commit;
  logic                alloc_fire, wb_fire;
  logic [IDX_W-1:0]    off_f, off_i;

  assign alloc_ready = (count_q != CNT_W'(DEPTH)) && !flush_valid && !flush_all;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign wb_fire     = wb_valid && valid_q[wb_idx] && !flush_all;
  assign alloc_idx   = tail_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign exc_valid   = (count_q != '0) && valid_q[head_q] && done_q[head_q] && exc_q[head_q];
  assign exc_idx     = head_q;
  assign exc_pc      = pc_q[head_q];

  // Commit lanes: an unbroken run of completed, non-faulting entries from head.
  always_comb begin
    elig            = '0;
    chain           = 1'b1;
    n_commit        = '0;
    commit_valid    = '0;
    commit_has_dest = '0;
    commit_dest     = '0;
    commit_old_dest = '0;
    commit_value    = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      lane_idx[k] = head_q + IDX_W'(k);
      chain = chain && (CNT_W'(k) < count_q) && valid_q[lane_idx[k]] &&
              done_q[lane_idx[k]] && !exc_q[lane_idx[k]];
      elig[k]         = chain;
      commit_valid[k] = chain && commit_ready && !flush_all;
      n_commit        = n_commit + CNT_W'(commit_valid[k]);
      commit_has_dest[k]                  = has_dest_q[lane_idx[k]];
      commit_dest[k*PREG_W +: PREG_W]     = dest_q[lane_idx[k]];
      commit_old_dest[k*PREG_W +: PREG_W] = old_dest_q[lane_idx[k]];
      commit_value[k*DATA_W +: DATA_W]    = value_q[lane_idx[k]];
    end
  end

  // Next state: commit, writeback, allocate, then flushes override.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    head_d  = head_q + IDX_W'(n_commit);
    tail_d  = tail_q + IDX_W'(alloc_fire);
    count_d = count_q + CNT_W'(alloc_fire) - n_commit;
    off_f   = flush_idx - head_q;
    off_i   = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (commit_valid[k]) valid_d[lane_idx[k]] = 1'b0;
    end
    if (wb_fire) begin
      done_d[wb_idx] = 1'b1;
      exc_d[wb_idx]  = wb_exc;
    end
    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      exc_d[tail_q]   = 1'b0;
    end
    if (flush_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        off_i = IDX_W'(i) - head_q;
        if (off_i > off_f) valid_d[i] = 1'b0;
      end
      tail_d = flush_idx + IDX_W'(1);
      // Widened so a flush at the newest entry of a full buffer keeps DEPTH.
      count_d = CNT_W'(off_f) + CNT_W'(1) - n_commit;
    end
    if (flush_all) begin
      valid_d = '0;
      done_d  = '0;
      exc_d   = '0;
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
    end
  end

  // Payload storage carries no reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_q]       <= alloc_pc;
      has_dest_q[tail_q] <= alloc_has_dest;
      dest_q[tail_q]     <= alloc_dest;
      old_dest_q[tail_q] <= alloc_old_dest;
    end
    if (wb_fire) value_q[wb_idx] <= wb_value;
  end

endmodule

// File: tb/tb_rob_multi.sv
// Scoreboard bench for rob_multi: program-order queue model, negedge monitor.
module tb_rob_multi;

  localparam int DEPTH = 64;
  localparam int IDX_W = 6;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          alloc_valid = 0, alloc_has_dest = 0;
  logic [31:0]   alloc_pc = '0;
  logic [5:0]    alloc_dest = '0, alloc_old_dest = '0;
  logic          alloc_ready;
  logic [5:0]    alloc_idx;
  logic          wb_valid = 0, wb_exc = 0;
  logic [5:0]    wb_idx = '0;
  logic [31:0]   wb_value = '0;
  logic          commit_ready = 1'b1;
  logic [1:0]    commit_valid, commit_has_dest;
  logic [11:0]   commit_dest, commit_old_dest;
  logic [63:0]   commit_value;
  logic          exc_valid;
  logic [5:0]    exc_idx;
  logic [31:0]   exc_pc;
  logic          flush_valid = 0, flush_all = 0;
  logic [5:0]    flush_idx = '0;
  logic [6:0]    count;
  logic          empty;

  rob_multi dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_has_dest(alloc_has_dest),
    .alloc_dest(alloc_dest), .alloc_old_dest(alloc_old_dest),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value), .wb_exc(wb_exc),
    .commit_ready(commit_ready), .commit_valid(commit_valid),
    .commit_has_dest(commit_has_dest), .commit_dest(commit_dest),
    .commit_old_dest(commit_old_dest), .commit_value(commit_value),
    .exc_valid(exc_valid), .exc_idx(exc_idx), .exc_pc(exc_pc),
    .flush_valid(flush_valid), .flush_idx(flush_idx), .flush_all(flush_all),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] pc;
    logic        hd;
    logic [5:0]  dest;
    logic [5:0]  od;
    logic [31:0] val;
    bit          done;
    bit          exc;
  } ent_t;

  ent_t        mq[$];
  logic [5:0]  m_tail = '0;
  int          n_checks = 0;
  int          n_errs = 0;
  int          n_retired = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs to the model, then advance the model by one edge.
  always @(negedge clk) begin
    int   cnt, n, p;
    bit   ar, ev;
    logic [1:0] ecv;
    ent_t e;
    if (!reset_n) begin
      mq.delete();
      m_tail = '0;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_commit_valid", 64'(commit_valid), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_alloc_idx", 64'(alloc_idx), 64'd0);
    end else begin
      cnt = mq.size();
      ar  = (cnt != DEPTH) && !flush_valid && !flush_all;
      n   = 0;
      if (commit_ready && !flush_all)
        while (n < CW && n < cnt && mq[n].done && !mq[n].exc) n++;
      ecv = '0;
      for (int k = 0; k < n; k++) ecv[k] = 1'b1;
      ev = (cnt > 0) && mq[0].done && mq[0].exc;

      chk("alloc_ready", 64'(alloc_ready), 64'(ar));
      chk("alloc_idx", 64'(alloc_idx), 64'(m_tail));
      chk("count", 64'(count), 64'(cnt));
      chk("empty", 64'(empty), 64'(cnt == 0));
      chk("commit_valid", 64'(commit_valid), 64'(ecv));
      chk("exc_valid", 64'(exc_valid), 64'(ev));
      if (ev) begin
        chk("exc_idx", 64'(exc_idx), 64'(mq[0].idx));
        chk("exc_pc", 64'(exc_pc), 64'(mq[0].pc));
      end
      for (int k = 0; k < n; k++) begin
        chk("lane_has_dest", 64'(commit_has_dest[k]), 64'(mq[k].hd));
        chk("lane_dest", 64'(commit_dest[k*6 +: 6]), 64'(mq[k].dest));
        chk("lane_old_dest", 64'(commit_old_dest[k*6 +: 6]), 64'(mq[k].od));
        chk("lane_value", 64'(commit_value[k*32 +: 32]), 64'(mq[k].val));
      end

      if (flush_all) begin
        mq.delete();
      end else begin
        if (wb_valid)
          foreach (mq[i]) if (mq[i].idx == wb_idx) begin
            mq[i].done = 1'b1;
            mq[i].val  = wb_value;
            mq[i].exc  = wb_exc;
          end
        if (flush_valid) begin
          p = -1;
          foreach (mq[i]) if (mq[i].idx == flush_idx) p = i;
          if (p >= 0) while (mq.size() > p + 1) void'(mq.pop_back());
          m_tail = flush_idx + 6'd1;
        end
        for (int k = 0; k < n; k++) void'(mq.pop_front());
        n_retired += n;
        if (ar && alloc_valid) begin
          e.idx = m_tail; e.pc = alloc_pc; e.hd = alloc_has_dest;
          e.dest = alloc_dest; e.od = alloc_old_dest; e.val = '0;
          e.done = 1'b0; e.exc = 1'b0;
          mq.push_back(e);
          m_tail = m_tail + 6'd1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic rand_alloc_fields();
    alloc_pc       = $urandom;
    alloc_has_dest = 1'($urandom_range(0, 1));
    alloc_dest     = 6'($urandom);
    alloc_old_dest = 6'($urandom);
  endtask

  task automatic do_reset();
    alloc_valid = 0; wb_valid = 0; flush_valid = 0; flush_all = 0; commit_ready = 1;
    reset_n = 0;
    repeat (2) cyc();
    reset_n = 1;
    cyc();
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1; rand_alloc_fields();
      cyc();
    end
    alloc_valid = 0;
  endtask

  task automatic wb(input logic [5:0] idx, input logic ex);
    wb_valid = 1; wb_idx = idx; wb_value = $urandom; wb_exc = ex;
    cyc();
    wb_valid = 0; wb_exc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, cand[$];
    do_reset();

    // Fill to capacity; extra requests are refused.
    alloc_n(66);
    chk("full_count", 64'(count), 64'd64);
    chk("full_ready", 64'(alloc_ready), 64'd0);

    // Out-of-order writeback, in-order dual commit.
    do_reset();
    alloc_n(4);
    wb(6'd1, 0); wb(6'd0, 0); wb(6'd3, 0); wb(6'd2, 0);
    repeat (3) cyc();
    chk("ooo_drain_count", 64'(count), 64'd0);

    // Exception at idx1 halts retirement until flush_all.
    do_reset();
    alloc_n(3);
    wb(6'd0, 0); wb(6'd1, 1); wb(6'd2, 0);
    repeat (3) cyc();
    chk("exc_hold_count", 64'(count), 64'd2);
    chk("exc_hold_valid", 64'(exc_valid), 64'd1);
    chk("exc_hold_idx", 64'(exc_idx), 64'd1);
    flush_all = 1; cyc(); flush_all = 0;
    chk("flush_all_count", 64'(count), 64'd0);
    chk("flush_all_empty", 64'(empty), 64'd1);

    // Partial flush concurrent with a two-lane commit.
    do_reset();
    commit_ready = 0;
    alloc_n(10);
    wb(6'd0, 0); wb(6'd1, 0);
    commit_ready = 1; flush_valid = 1; flush_idx = 6'd4;
    cyc();
    flush_valid = 0; commit_ready = 0;
    wb(6'd7, 0);
    cyc();
    chk("pflush_count", 64'(count), 64'd3);
    chk("pflush_tail", 64'(alloc_idx), 64'd5);

    // Wrap: 150 entries streamed with commit_ready toggling.
    do_reset();
    r0 = n_retired;
    for (int c = 0; c < 200; c++) begin
      alloc_valid = (c < 150);
      rand_alloc_fields();
      commit_ready = (c % 2 == 0);
      wb_valid = 0;
      foreach (mq[i]) if (!mq[i].done && !wb_valid) begin
        wb_valid = 1; wb_idx = mq[i].idx; wb_value = $urandom; wb_exc = 0;
      end
      cyc();
    end
    alloc_valid = 0; wb_valid = 0; commit_ready = 1;
    cyc();
    chk("wrap_retired", 64'(n_retired - r0), 64'd150);
    chk("wrap_count", 64'(count), 64'd0);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      alloc_valid = ($urandom_range(0, 99) < 60);
      rand_alloc_fields();
      commit_ready = ($urandom_range(0, 99) < 75);
      wb_valid = 0; wb_exc = 0;
      cand.delete();
      foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 99) < 70) begin
        wb_valid = 1;
        wb_idx   = mq[cand[$urandom_range(0, cand.size() - 1)]].idx;
        wb_value = $urandom;
        wb_exc   = ($urandom_range(0, 99) < 3);
      end else if ($urandom_range(0, 99) < 10) begin
        wb_valid = 1; wb_idx = 6'($urandom); wb_value = $urandom;
      end
      flush_valid = 0;
      if (mq.size() > 2 && $urandom_range(0, 99) < 3) begin
        flush_valid = 1;
        flush_idx   = mq[$urandom_range(2, mq.size() - 1)].idx;
      end
      flush_all = ($urandom_range(0, 199) == 0) ||
                  (mq.size() > 0 && mq[0].done && mq[0].exc && $urandom_range(0, 3) == 0);
      cyc();
    end
    alloc_valid = 0; wb_valid = 0; flush_valid = 0; flush_all = 1;
    cyc();
    flush_all = 0;
    chk("rand_end_empty", 64'(empty), 64'd1);

    // Asynchronous reset with 20 entries and live commits.
    do_reset();
    commit_ready = 0;
    alloc_n(20);
    wb(6'd0, 0); wb(6'd1, 0);
    chk("pre_rst_count", 64'(count), 64'd20);
    commit_ready = 1;
    #2;
    chk("pre_rst_commit", 64'(commit_valid), 64'd3);
    reset_n = 0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_commit", 64'(commit_valid), 64'd0);
    chk("async_rst_ready", 64'(alloc_ready), 64'd1);
    cyc();
    reset_n = 1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
